// File: rtl/insn_loader_encoder_pkg.sv
// Shared opcode, format and field-position definitions for the instruction
// encoder/loader. The processor's control decoder uses the same opcode table.
package insn_loader_encoder_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  // Field positions (LSB of each 5-bit field) and immediate widths
  localparam int OP_LSB    = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int SHAMT_LSB = 7;
  localparam int ALUOP_LSB = 2;
  localparam int IMM_I_W   = 17;
  localparam int TARGET_W  = 27;
  localparam int WORD_W    = 32;

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_JI      = 3'd2,
    FMT_JII     = 3'd3,
    FMT_ILLEGAL = 3'd4
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Map an opcode to its instruction format; anything unlisted is illegal.
  function automatic fmt_e opcode_fmt(input logic [4:0] op);
    fmt_e f;
    case (op)
      OP_ALU:                              f = FMT_R;
      OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT: f = FMT_I;
      OP_J, OP_JAL, OP_BEX, OP_SETX:       f = FMT_JI;
      OP_JR:                               f = FMT_JII;
      default:                             f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/insn_word_fifo.sv
// Small synchronous FIFO holding encoded words plus their last-of-session tag.
// Overflowing pushes and underflowing pops are ignored.
module insn_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  // Count reaches exactly DEPTH (a power of two) only when full
  assign empty   = (count_q == '0);
  assign full    = count_q[PW];
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next-state for storage, pointers and occupancy; clear wins over traffic
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/insn_loader_encoder.sv
// Encodes field-level instruction requests into 32-bit words, buffers them
// and streams them one per cycle into sequential imem addresses.
module insn_loader_encoder
  import insn_loader_encoder_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter int          AW         = 12,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [4:0]    req_opcode,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_rs,
  input  logic [4:0]    req_rt,
  input  logic [4:0]    req_shamt,
  input  logic [4:0]    req_aluop,
  input  logic [31:0]   req_imm,
  input  logic          req_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_data,
  output logic          done,
  output logic          err_illegal,
  output logic          err_range
);

  // Pack request fields according to the instruction format
  function automatic logic [WORD_W-1:0] encode_word(
    input fmt_e        fmt,
    input logic [4:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  shamt,
    input logic [4:0]  aluop,
    input logic [31:0] imm
  );
    logic [WORD_W-1:0] w;
    w = 32'd0;
    w[OP_LSB +: 5] = op;
    case (fmt)
      FMT_R: begin
        w[RD_LSB    +: 5] = rd;
        w[RS_LSB    +: 5] = rs;
        w[RT_LSB    +: 5] = rt;
        w[SHAMT_LSB +: 5] = shamt;
        w[ALUOP_LSB +: 5] = aluop;
      end
      FMT_I: begin
        w[RD_LSB +: 5]    = rd;
        w[RS_LSB +: 5]    = rs;
        w[IMM_I_W-1:0]    = imm[IMM_I_W-1:0];
      end
      FMT_JI:  w[TARGET_W-1:0] = imm[TARGET_W-1:0];
      FMT_JII: w[RD_LSB +: 5]  = rd;
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // True when the immediate loses information once truncated to its field
  function automatic logic imm_out_of_range(input fmt_e fmt, input logic [31:0] imm);
    logic bad;
    case (fmt)
      FMT_I:   bad = (imm[31:IMM_I_W] != {(32-IMM_I_W){imm[IMM_I_W-1]}});
      FMT_JI:  bad = (imm[31:TARGET_W] != 5'd0);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            err_illegal_q, err_illegal_d;
  logic            err_range_q, err_range_d;
  logic            last_seen_q, last_seen_d;   // last request already accepted
  logic            drop_last_q, drop_last_d;   // last request was an illegal (dropped) one

  fmt_e            req_fmt_s;
  logic [31:0]     enc_word_s;
  logic            accept_s, push_s, pop_s, clear_s;
  logic [32:0]     head_s;
  logic            fifo_empty_s, fifo_full_s;

  assign req_fmt_s  = opcode_fmt(req_opcode);
  assign enc_word_s = encode_word(req_fmt_s, req_opcode, req_rd, req_rs, req_rt,
                                  req_shamt, req_aluop, req_imm);

  assign req_ready = (state_q == ST_LOAD) & ~fifo_full_s & ~last_seen_q;
  assign accept_s  = req_valid & req_ready;
  assign push_s    = accept_s & (req_fmt_s != FMT_ILLEGAL);
  assign pop_s     = (state_q == ST_LOAD) & ~fifo_empty_s;
  assign clear_s   = start & (state_q != ST_LOAD);

  assign imem_we     = pop_s;
  assign imem_addr   = addr_q;
  assign imem_data   = pop_s ? head_s[31:0] : 32'd0;
  assign done        = (state_q == ST_DONE);
  assign err_illegal = err_illegal_q;
  assign err_range   = err_range_q;

  insn_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (clear_s),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({req_last, enc_word_s}),
    .rdata (head_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  // Session FSM: next state, write address and sticky error flags
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    err_illegal_d = err_illegal_q;
    err_range_d   = err_range_q;
    last_seen_d   = last_seen_q;
    drop_last_d   = drop_last_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_LOAD;
          addr_d        = AW'(BASE_ADDR);
          err_illegal_d = 1'b0;
          err_range_d   = 1'b0;
          last_seen_d   = 1'b0;
          drop_last_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (pop_s) begin
          addr_d = addr_q + AW'(1);
        end else begin
          addr_d = addr_q;
        end
        if (accept_s) begin
          if (req_fmt_s == FMT_ILLEGAL) begin
            err_illegal_d = 1'b1;
            drop_last_d   = drop_last_q | req_last;
          end else begin
            err_range_d = err_range_q | imm_out_of_range(req_fmt_s, req_imm);
          end
          last_seen_d = last_seen_q | req_last;
        end else begin
          last_seen_d = last_seen_q;
        end
        // A dropped last request ends the session once everything queued is out
        if (pop_s && head_s[32]) begin
          state_d = ST_DONE;
        end else if (drop_last_q && fifo_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= AW'(BASE_ADDR);
      err_illegal_q <= 1'b0;
      err_range_q   <= 1'b0;
      last_seen_q   <= 1'b0;
      drop_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      err_illegal_q <= err_illegal_d;
      err_range_q   <= err_range_d;
      last_seen_q   <= last_seen_d;
      drop_last_q   <= drop_last_d;
    end
  end

endmodule

// File: tb/tb_insn_loader_encoder.sv
// Directed bench for insn_loader_encoder with hand-computed expected words.
module tb_insn_loader_encoder;

  logic        clock = 1'b0;
  logic        reset, start, req_valid, req_ready, req_last;
  logic [4:0]  req_opcode, req_rd, req_rs, req_rt, req_shamt, req_aluop;
  logic [31:0] req_imm;
  logic        imem_we, done, err_illegal, err_range;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;

  int n_cmp = 0;
  int n_err = 0;
  int stalls = 0;
  int nw = 0;
  logic [11:0] wa [64];
  logic [31:0] wd [64];

  insn_loader_encoder #(.FIFO_DEPTH(4), .AW(12), .BASE_ADDR(0)) dut (
    .clock(clock), .reset(reset), .start(start),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_rd(req_rd), .req_rs(req_rs), .req_rt(req_rt),
    .req_shamt(req_shamt), .req_aluop(req_aluop), .req_imm(req_imm), .req_last(req_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .done(done), .err_illegal(err_illegal), .err_range(err_range)
  );

  always #5 clock = ~clock;

  // Record every imem write, sampled mid-cycle
  always @(negedge clock) begin
    if (imem_we) begin
      if (nw < 64) begin
        wa[nw] = imem_addr;
        wd[nw] = imem_data;
      end
      nw = nw + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge; return at the negedge after it is accepted
  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] alu,
                      input logic [31:0] imm, input logic last);
    int t;
    req_valid = 1'b1; req_opcode = op; req_rd = rd; req_rs = rs; req_rt = rt;
    req_shamt = sh; req_aluop = alu; req_imm = imm; req_last = last;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clock);
      t++;
    end
    if (!req_ready) check("send_timeout", {31'd0, req_ready}, 32'd1);
    stalls = stalls + t;
    @(negedge clock);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  task automatic start_session();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 40) begin
      @(negedge clock);
      t++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  logic [31:0] c_exp [6] = '{32'h2800_0000, 32'h2840_0001, 32'h2880_0002,
                             32'h28C0_0003, 32'h2900_0004, 32'h2940_0005};

  initial begin
    int s0;
    reset = 1'b1; start = 1'b0; req_valid = 1'b0; req_last = 1'b0;
    req_opcode = 5'd0; req_rd = 5'd0; req_rs = 5'd0; req_rt = 5'd0;
    req_shamt = 5'd0; req_aluop = 5'd0; req_imm = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", {20'd0, imem_addr}, 32'd0);
    check("rst_data", imem_data, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {30'd0, err_illegal, err_range}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_ready", {31'd0, req_ready}, 32'd0);

    // A: single addi with last, one-cycle latency, done after
    start_session();
    check("a_ready", {31'd0, req_ready}, 32'd1);
    send(5'b00101, 5'd3, 5'd1, 5'd0, 5'd0, 5'd0, 32'd5, 1'b1); idle();
    check("a_we", {31'd0, imem_we}, 32'd1);
    check("a_addr", {20'd0, imem_addr}, 32'd0);
    check("a_data", imem_data, 32'h28C2_0005);
    @(negedge clock);
    check("a_done", {31'd0, done}, 32'd1);
    check("a_we_off", {31'd0, imem_we}, 32'd0);
    check("a_ready_done", {31'd0, req_ready}, 32'd0);

    // B: R-type packing, start ignored in LOAD, negative immediate
    start_session();
    send(5'b00000, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 32'd0, 1'b0); idle();
    check("b_add_addr", {20'd0, imem_addr}, 32'd0);
    check("b_add_data", imem_data, 32'h0044_3000);
    start_session();
    check("b_load_ready", {31'd0, req_ready}, 32'd1);
    send(5'b00000, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 32'd0, 1'b0); idle();
    check("b_rmax_addr", {20'd0, imem_addr}, 32'd1);
    check("b_rmax_data", imem_data, 32'h0000_0FFC);
    send(5'b00101, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1); idle();
    check("b_neg_addr", {20'd0, imem_addr}, 32'd2);
    check("b_neg_data", imem_data, 32'h2801_FFFF);
    check("b_neg_range", {31'd0, err_range}, 32'd0);
    wait_done("b_done");

    // C: six back-to-back requests, draining continuously
    start_session();
    s0 = nw; stalls = 0;
    for (int i = 0; i < 6; i++)
      send(5'b00101, 5'(i), 5'd0, 5'd0, 5'd0, 5'd0, 32'(i), (i == 5));
    idle();
    wait_done("c_done");
    check("c_stalls", 32'(stalls), 32'd0);
    check("c_count", 32'(nw - s0), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("c_addr", {20'd0, wa[s0+i]}, 32'(i));
      check("c_data", wd[s0+i], c_exp[i]);
    end

    // D: illegal opcode between two valid ones, then j target
    start_session();
    s0 = nw;
    send(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 32'd1, 1'b0);
    send(5'b11111, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 32'd7, 1'b0);
    send(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0100, 1'b1);
    idle();
    wait_done("d_done");
    check("d_count", 32'(nw - s0), 32'd2);
    check("d_addr0", {20'd0, wa[s0]}, 32'd0);
    check("d_data0", wd[s0], 32'h2840_0001);
    check("d_addr1", {20'd0, wa[s0+1]}, 32'd1);
    check("d_data1", wd[s0+1], 32'h0800_0100);
    check("d_illegal", {31'd0, err_illegal}, 32'd1);
    check("d_range", {31'd0, err_range}, 32'd0);

    // E: range errors, max JI target, jr packing
    start_session();
    check("e_illegal_clr", {31'd0, err_illegal}, 32'd0);
    send(5'b10101, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h07FF_FFFF, 1'b0); idle();
    check("e_setx_data", imem_data, 32'hAFFF_FFFF);
    check("e_setx_range", {31'd0, err_range}, 32'd0);
    send(5'b00101, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0002_0000, 1'b0); idle();
    check("e_addi_data", imem_data, 32'h2800_0000);
    check("e_addi_range", {31'd0, err_range}, 32'd1);
    send(5'b00100, 5'd31, 5'd5, 5'd5, 5'd5, 5'd5, 32'hFFFF_FFFF, 1'b1); idle();
    check("e_jr_data", imem_data, 32'h27C0_0000);
    wait_done("e_done");
    start_session();
    check("e_range_clr", {31'd0, err_range}, 32'd0);
    send(5'b00011, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0800_0000, 1'b1); idle();
    check("e_jal_data", imem_data, 32'h1800_0000);
    check("e_jal_range", {31'd0, err_range}, 32'd1);
    wait_done("e_jal_done");

    // Illegal request carrying last still ends the session
    start_session();
    s0 = nw;
    send(5'b11111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1); idle();
    wait_done("e_ill_done");
    check("e_ill_count", 32'(nw - s0), 32'd0);
    check("e_ill_flag", {31'd0, err_illegal}, 32'd1);

    // F: reset mid-session
    start_session();
    send(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 32'd1, 1'b0);
    send(5'b00101, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 32'd2, 1'b0);
    send(5'b00101, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 32'd3, 1'b0);
    idle();
    reset = 1'b1;
    @(negedge clock);
    check("f_we", {31'd0, imem_we}, 32'd0);
    check("f_ready", {31'd0, req_ready}, 32'd0);
    check("f_addr", {20'd0, imem_addr}, 32'd0);
    reset = 1'b0;
    s0 = nw;
    repeat (3) @(negedge clock);
    check("f_no_writes", 32'(nw - s0), 32'd0);
    check("f_idle_ready", {31'd0, req_ready}, 32'd0);
    start_session();
    send(5'b00101, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 32'd4, 1'b1); idle();
    check("f_restart_addr", {20'd0, imem_addr}, 32'd0);
    check("f_restart_data", imem_data, 32'h2900_0004);
    wait_done("f_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
